// File: rtl/booth_mult_r4.sv
// rtl/booth_mult_r4.sv - radix-4 Booth sequential multiplier (signed mode under BOOTH_MULT_SIGNED_EN)
module booth_mult_r4 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 srst,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 op_ld,
    input  logic                 op_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mult_out
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int BW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mcand;
    logic [BW-1:0]   mq;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic            sgn;

`ifdef BOOTH_MULT_SIGNED_EN
    assign sgn = op_signed;
`else
    assign sgn = op_signed & 1'b0;
`endif

    logic [AW-1:0]      pp;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      acc_nx;
    logic [BW-1:0]      mq_nx;
    logic [2*WIDTH-1:0] prod;

    // One Booth digit from {mq[1:0], qm1}, add, then arithmetic shift of {acc, mq} by 2
    always_comb begin
        pp = '0;
        case ({mq[1:0], qm1})
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        sum    = acc + pp;
        acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mq_nx  = {sum[1:0], mq[BW-1:2]};
        prod   = {acc_nx[WIDTH-3:0], mq_nx};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mult_out <= '0;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
        end else if (srst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mult_out <= '0;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (op_ld) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        mcand <= {{4{sgn & opa[WIDTH-1]}}, opa};
                        mq    <= {{2{sgn & opb[WIDTH-1]}}, opb};
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    qm1 <= mq[1];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mult_out <= prod;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_r4.sv
// tb/tb_booth_mult_r4.sv - self-checking bench for booth_mult_r4 (WIDTH=16)
module tb_booth_mult_r4;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        srst = 1'b0;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic        op_ld = 1'b0;
    logic        op_signed = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] mult_out;

    int n_checks = 0;
    int n_fail = 0;

`ifdef BOOTH_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    booth_mult_r4 #(.WIDTH(16)) dut (
        .clk(clk), .arst(arst), .srst(srst), .opa(opa), .opb(opb),
        .op_ld(op_ld), .op_signed(op_signed), .busy(busy), .done(done),
        .mult_out(mult_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint ea, eb;
        bit sg;
        sg = s & SIGNED_EN;
        ea = sg ? longint'($signed(a)) : longint'(a);
        eb = sg ? longint'($signed(b)) : longint'(b);
        return 32'(ea * eb);
    endfunction

    task automatic wait_done(input int b0, output int lat, output int bcnt);
        lat = -1;
        bcnt = b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bcnt += int'(busy);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat, output int bcnt);
        @(negedge clk);
        opa = a; opb = b; op_signed = s; op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        wait_done(int'(busy), lat, bcnt);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, mult_out} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h expected 0 0 0", busy, done, mult_out);
        end
        arst = 1'b0;
    endtask

    task automatic test_directed;
        int lat, bcnt;
        logic [31:0] exp2;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bcnt);
        n_checks++;
        if (mult_out !== 32'hFFFE0001) begin
            n_fail++; $display("FAIL unsigned_max: got %h expected fffe0001", mult_out);
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++; $display("FAIL done_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if (bcnt !== 9) begin
            n_fail++; $display("FAIL busy_cycles: got %0d expected 9", bcnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done);
        end
        run_op(16'h8000, 16'h8000, 1'b1, lat, bcnt);
        n_checks++;
        if (mult_out !== 32'h40000000) begin
            n_fail++; $display("FAIL signed_minneg: got %h expected 40000000", mult_out);
        end
        exp2 = SIGNED_EN ? 32'h00000001 : 32'hFFFE0001;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, lat, bcnt);
        n_checks++;
        if (mult_out !== exp2) begin
            n_fail++; $display("FAIL signed_m1: got %h expected %h", mult_out, exp2);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_op(16'd40956, 16'd47281, 1'b0, lat, bcnt);
        n_checks++;
        if (mult_out !== 32'd1936440636) begin
            n_fail++; $display("FAIL b2b_first: got %0d expected 1936440636", mult_out);
        end
        opa = 16'd1; opb = 16'd4; op_signed = 1'b0; op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(int'(busy), lat, bcnt);
        n_checks++;
        if (mult_out !== 32'd4 || lat !== 9) begin
            n_fail++; $display("FAIL b2b_second: got %0d lat %0d expected 4 lat 9", mult_out, lat);
        end
    endtask

    task automatic test_ignore_busy;
        int lat, extra;
        logic [31:0] held;
        @(negedge clk);
        opa = 16'd1234; opb = 16'd567; op_signed = 1'b0; op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin opa = 16'd3; opb = 16'd3; op_ld = 1'b1; end
            if (i == 5) op_ld = 1'b0;
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        n_checks++;
        if (mult_out !== 32'd699678 || lat !== 9) begin
            n_fail++; $display("FAIL ignore_busy: got %0d lat %0d expected 699678 lat 9", mult_out, lat);
        end
        held = mult_out;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            extra += int'(done);
        end
        n_checks++;
        if (extra !== 0 || mult_out !== held) begin
            n_fail++; $display("FAIL no_extra_done: got %0d pulses out %h expected 0 pulses out %h", extra, mult_out, held);
        end
    endtask

    task automatic test_abort;
        int lat, bcnt, pulses;
        run_op(16'd300, 16'd7, 1'b0, lat, bcnt);
        @(negedge clk);
        opa = 16'd999; opb = 16'd999; op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, mult_out} !== 34'd0) begin
            n_fail++; $display("FAIL arst_abort: got busy=%b done=%b out=%h expected 0 0 0", busy, done, mult_out);
        end
        @(negedge clk);
        arst = 1'b0;
        pulses = 0;
        repeat (15) begin @(negedge clk); pulses += int'(done) + int'(busy); end
        n_checks++;
        if (pulses !== 0 || mult_out !== 32'd0) begin
            n_fail++; $display("FAIL arst_no_done: got %0d activity out %h expected 0 out 0", pulses, mult_out);
        end
        run_op(16'd300, 16'd7, 1'b0, lat, bcnt);
        @(negedge clk);
        opa = 16'd5; opb = 16'd5; op_ld = 1'b1; srst = 1'b1;
        @(negedge clk);
        op_ld = 1'b0; srst = 1'b0;
        n_checks++;
        if ({busy, done, mult_out} !== 34'd0) begin
            n_fail++; $display("FAIL srst_priority: got busy=%b done=%b out=%h expected 0 0 0", busy, done, mult_out);
        end
        pulses = 0;
        repeat (15) begin @(negedge clk); pulses += int'(done) + int'(busy); end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL srst_no_op: got %0d activity expected 0", pulses);
        end
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [15:0] a, b;
        logic s;
        logic [31:0] exp;
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (k % 8 == 0) a = 16'h8000;
            if (k % 8 == 1) b = 16'h7FFF;
            s = 1'($urandom);
            exp = model(a, b, s);
            run_op(a, b, s, lat, bcnt);
            n_checks++;
            if (mult_out !== exp || lat !== 9 || bcnt !== 9) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got %h lat %0d busy %0d expected %h lat 9 busy 9",
                         k, a, b, s, mult_out, lat, bcnt, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_ignore_busy;
        test_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mult_r4.md
BOOTH_MULT_R4 -- requirements
Module: booth_mult_r4

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; even, >= 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: arst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: srst  input  1  synchronous clear, active-high.
REQ-005 SHALL have port: opa  input  WIDTH  multiplicand.
REQ-006 SHALL have port: opb  input  WIDTH  multiplier.
REQ-007 SHALL have port: op_ld  input  1  load request; opa/opb/op_signed sampled with it.
REQ-008 SHALL have port: op_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking a new result on mult_out.
REQ-011 SHALL have port: mult_out  output  2*WIDTH  product register.

Function
REQ-012 SHALL implement a radix-4 Booth sequential multiplier with states IDLE, CALC and DONE.
REQ-013 SHALL extend opb to WIDTH+2 bits: sign-extended if op_signed=1, zero-extended if 0.
REQ-014 SHALL run exactly N = WIDTH/2+1 iterations per operation, independent of operand values.
REQ-015 SHALL accept op_ld only at an edge where busy=0 (state IDLE or DONE); op_ld with busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-016 SHALL, on acceptance at edge E0, latch operands and mode, enter CALC, and assert busy from E0.
REQ-017 SHALL perform one Booth recoding step (digit in {-2,-1,0,+1,+2}, partial-product add, 2-bit arithmetic shift) per CALC edge, on edges E1..EN.
REQ-018 SHALL, at edge EN, load mult_out with the full 2*WIDTH-bit product, deassert busy, enter DONE, and assert done for exactly one cycle.
REQ-019 SHALL hold mult_out unchanged from EN until the next completed operation.
REQ-020 SHALL, from DONE, accept a new op_ld (back-to-back, new E0 at EN+1); otherwise it SHALL return to IDLE.
REQ-021 SHALL compute the exact product modulo 2^(2*WIDTH): unsigned mode gives opa*opb, and signed mode gives the two's-complement product, including for the most negative operand.
REQ-022 SHALL make srst=1 at an edge clear state as arst does, with priority over op_ld.

Reset
REQ-023 SHALL, while arst=1, force state IDLE, busy=0, done=0, mult_out=0, and clear the iteration counter and datapath registers.
REQ-024 SHALL abort an operation in progress on arst or srst, without asserting done and with no partial result on mult_out.

Configuration
REQ-025 SHALL compile signed mode only when macro BOOTH_MULT_SIGNED_EN is defined; without it, op_signed SHALL be ignored, all operations SHALL be unsigned, and the port list SHALL be unchanged.

Verification (WIDTH=16, BOOTH_MULT_SIGNED_EN defined)
REQ-026 SHALL cover: unsigned opa=65535, opb=65535 -> mult_out=0xFFFE0001, with done pulsed 9 edges after the accept edge and busy high for 9 cycles.
REQ-027 SHALL cover: signed opa=0x8000, opb=0x8000 -> mult_out=0x40000000; signed opa=0xFFFF, opb=0xFFFF -> 0x00000001.
REQ-028 SHALL cover: unsigned opa=40956, opb=47281 -> 1936440636, then back-to-back op_ld in the DONE cycle with opa=1, opb=4 -> 4 after a further 9 edges.
REQ-029 SHALL cover: op_ld re-asserted with opa=3, opb=3 during busy -> ignored; the first result is unaffected and no extra done pulse occurs.
REQ-030 SHALL cover: arst pulse mid-CALC -> busy=0, mult_out=0, no done pulse; srst with op_ld asserted together -> IDLE, with the load ignored.
